fft_peak_analyzer: RTL and testbench

FFT_PEAK_ANALYZER -- requirements
Module: fft_peak_analyzer

---
 rtl/fft_peak_analyzer.sv | 132 +++++++++++++
 tb/tb_fft_peak_analyzer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_analyzer.sv
// Scans a captured 16-bin FFT frame, one bin per cycle, and reports the index of the largest |X|^2.
// Optional macro PEAK_MAG_OUT_EN adds the peak_mag output carrying the winning magnitude.
module fft_peak_analyzer #(
  parameter logic [31:0] MIN_MAG = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
`ifdef PEAK_MAG_OUT_EN
  output logic [31:0] peak_mag,
`endif
  output logic        busy,
  output logic        done,
  output logic [3:0]  freq,
  output logic        nopeak,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic [31:0]        max_q;
  logic [3:0]         idx_q;
  logic [31:0]        frame_q [16];
  logic [31:0]        fft_in_w [16];
  logic               capture_w;
  logic [31:0]        bin_w;
  logic signed [15:0] re_w;
  logic signed [15:0] im_w;
  logic signed [31:0] re_ext_w;
  logic signed [31:0] im_ext_w;
  logic signed [31:0] re_sq_w;
  logic signed [31:0] im_sq_w;
  logic [31:0]        mag_w;

  assign fft_in_w = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                      fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  assign capture_w = fft_valid && (state_q != SCAN);

  assign bin_w    = frame_q[cnt_q];
  assign re_w     = bin_w[31:16];
  assign im_w     = bin_w[15:0];
  assign re_ext_w = 32'(re_w);
  assign im_ext_w = 32'(im_w);
  assign re_sq_w  = re_ext_w * re_ext_w;
  assign im_sq_w  = im_ext_w * im_ext_w;
  // Each square is at most 2^30, so the unsigned sum tops out at exactly 2^31.
  assign mag_w    = $unsigned(re_sq_w) + $unsigned(im_sq_w);

  always_ff @(posedge clk) begin
    if (!rst && capture_w) begin
      frame_q <= fft_in_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      max_q    <= 32'd0;
      idx_q    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      freq     <= 4'd0;
      nopeak   <= 1'b0;
`ifdef PEAK_MAG_OUT_EN
      peak_mag <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      ovf  <= 1'b0;
      busy <= (state_q == SCAN);
      case (state_q)
        IDLE: begin
          if (fft_valid) begin
            state_q <= SCAN;
            cnt_q   <= 4'd0;
          end
        end
        SCAN: begin
          // Bin 0 seeds the running max; later bins must be strictly larger.
          if (cnt_q == 4'd0 || mag_w > max_q) begin
            max_q <= mag_w;
            idx_q <= cnt_q;
          end
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= REPORT;
          end
          if (fft_valid) begin
            ovf <= 1'b1;
          end
        end
        REPORT: begin
          done     <= 1'b1;
          freq     <= idx_q;
          nopeak   <= (max_q <= MIN_MAG);
`ifdef PEAK_MAG_OUT_EN
          peak_mag <= max_q;
`endif
          if (fft_valid) begin
            state_q <= SCAN;
            cnt_q   <= 4'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Directed bench for fft_peak_analyzer: latency, peak selection, ties, threshold, overrun and reset abort.
module tb_fft_peak_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fft_valid;
  logic [31:0] fr [16];
  logic        busy, done, nopeak, ovf;
  logic [3:0]  freq;
  logic        busy2, done2, nopeak2, ovf2;
  logic [3:0]  freq2;
`ifdef PEAK_MAG_OUT_EN
  logic [31:0] peak_mag, peak_mag2;
`endif

  int passed = 0;
  int total  = 0;

  fft_peak_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fr[0]), .fft_d1(fr[1]), .fft_d2(fr[2]), .fft_d3(fr[3]),
    .fft_d4(fr[4]), .fft_d5(fr[5]), .fft_d6(fr[6]), .fft_d7(fr[7]),
    .fft_d8(fr[8]), .fft_d9(fr[9]), .fft_d10(fr[10]), .fft_d11(fr[11]),
    .fft_d12(fr[12]), .fft_d13(fr[13]), .fft_d14(fr[14]), .fft_d15(fr[15]),
`ifdef PEAK_MAG_OUT_EN
    .peak_mag(peak_mag),
`endif
    .busy(busy), .done(done), .freq(freq), .nopeak(nopeak), .ovf(ovf)
  );

  // Second instance with a threshold of exactly 256^2 to probe the <= boundary.
  fft_peak_analyzer #(.MIN_MAG(32'h0001_0000)) dut_thr (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fr[0]), .fft_d1(fr[1]), .fft_d2(fr[2]), .fft_d3(fr[3]),
    .fft_d4(fr[4]), .fft_d5(fr[5]), .fft_d6(fr[6]), .fft_d7(fr[7]),
    .fft_d8(fr[8]), .fft_d9(fr[9]), .fft_d10(fr[10]), .fft_d11(fr[11]),
    .fft_d12(fr[12]), .fft_d13(fr[13]), .fft_d14(fr[14]), .fft_d15(fr[15]),
`ifdef PEAK_MAG_OUT_EN
    .peak_mag(peak_mag2),
`endif
    .busy(busy2), .done(done2), .freq(freq2), .nopeak(nopeak2), .ovf(ovf2)
  );

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) fr[i] = 32'd0;
  endtask

  // Sends the frame in fr, then watches 24 cycles. lat is the cycle index after the capture edge
  // at which done is first seen (-1 if never).
  task automatic run_frame(output int lat, output int ndone, output int busy_err,
                           output logic [3:0] f, output logic np, output logic [31:0] pm,
                           output logic np2, output logic [3:0] f_end);
    lat = -1; ndone = 0; busy_err = 0; f = 4'hx; np = 1'bx; pm = 32'hx; np2 = 1'bx;
    fft_valid = 1'b1;
    @(posedge clk); #1;
    fft_valid = 1'b0;
    if (busy !== 1'b0) busy_err++;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (busy !== (k <= 16)) busy_err++;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat = k; f = freq; np = nopeak; np2 = nopeak2;
`ifdef PEAK_MAG_OUT_EN
          pm = peak_mag;
`else
          pm = 32'd0;
`endif
        end
      end
    end
    f_end = freq;
  endtask

  task automatic test_reset();
    rst = 1'b1; fft_valid = 1'b0; clear_frame();
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done, ovf, nopeak} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {busy, done, ovf, nopeak}); else passed++;
    total++; if (freq !== 4'd0) $display("FAIL reset_freq: got %0d expected 0", freq); else passed++;
    fr[3] = 32'h0100_0000; fft_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; fft_valid = 1'b0;
    begin
      int nb = 0, nd = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (busy === 1'b1) nb++;
        if (done === 1'b1) nd++;
      end
      total++; if (nb !== 0) $display("FAIL valid_in_reset_busy: got %0d busy cycles expected 0", nb); else passed++;
      total++; if (nd !== 0) $display("FAIL valid_in_reset_done: got %0d done pulses expected 0", nd); else passed++;
    end
  endtask

  task automatic test_single_bin();
    int lat, nd, be; logic [3:0] f, fe; logic np, np2; logic [31:0] pm;
    clear_frame(); fr[1] = 32'h0100_0000;
    run_frame(lat, nd, be, f, np, pm, np2, fe);
    total++; if (lat !== 17) $display("FAIL single_latency: got %0d expected 17", lat); else passed++;
    total++; if (nd !== 1) $display("FAIL single_done_count: got %0d expected 1", nd); else passed++;
    total++; if (be !== 0) $display("FAIL single_busy_window: got %0d bad cycles expected 0", be); else passed++;
    total++; if (f !== 4'd1) $display("FAIL single_freq: got %0d expected 1", f); else passed++;
    total++; if (np !== 1'b0) $display("FAIL single_nopeak: got %b expected 0", np); else passed++;
    total++; if (np2 !== 1'b1) $display("FAIL thr_equal_nopeak: got %b expected 1", np2); else passed++;
    total++; if (fe !== 4'd1) $display("FAIL single_freq_hold: got %0d expected 1", fe); else passed++;
`ifdef PEAK_MAG_OUT_EN
    total++; if (pm !== 32'h0001_0000) $display("FAIL single_peak_mag: got %h expected 00010000", pm); else passed++;
`endif
  endtask

  task automatic test_tie();
    int lat, nd, be; logic [3:0] f, fe; logic np, np2; logic [31:0] pm;
    clear_frame(); fr[1] = 32'h0000_0200; fr[15] = 32'h0000_0200;
    run_frame(lat, nd, be, f, np, pm, np2, fe);
    total++; if (f !== 4'd1) $display("FAIL tie_freq: got %0d expected 1", f); else passed++;
  endtask

  task automatic test_max_neg();
    int lat, nd, be; logic [3:0] f, fe; logic np, np2; logic [31:0] pm;
    clear_frame(); fr[7] = 32'h8000_8000; fr[3] = 32'h7FFF_7FFF;
    run_frame(lat, nd, be, f, np, pm, np2, fe);
    total++; if (f !== 4'd7) $display("FAIL maxneg_freq: got %0d expected 7", f); else passed++;
    total++; if (np !== 1'b0) $display("FAIL maxneg_nopeak: got %b expected 0", np); else passed++;
`ifdef PEAK_MAG_OUT_EN
    total++; if (pm !== 32'h8000_0000) $display("FAIL maxneg_peak_mag: got %h expected 80000000", pm); else passed++;
`endif
  endtask

  task automatic test_all_zero();
    int lat, nd, be; logic [3:0] f, fe; logic np, np2; logic [31:0] pm;
    clear_frame();
    run_frame(lat, nd, be, f, np, pm, np2, fe);
    total++; if (f !== 4'd0) $display("FAIL zero_freq: got %0d expected 0", f); else passed++;
    total++; if (np !== 1'b1) $display("FAIL zero_nopeak: got %b expected 1", np); else passed++;
    total++; if (lat !== 17) $display("FAIL zero_latency: got %0d expected 17", lat); else passed++;
  endtask

  task automatic test_strict_order();
    int lat, nd, be; logic [3:0] f, fe; logic np, np2; logic [31:0] pm;
    clear_frame(); fr[0] = 32'h0001_0000; fr[5] = 32'h0003_0000; fr[9] = 32'hFFFD_0000;
    run_frame(lat, nd, be, f, np, pm, np2, fe);
    total++; if (f !== 4'd5) $display("FAIL strict_later_freq: got %0d expected 5", f); else passed++;
    clear_frame(); fr[0] = 32'hFFFB_0000; fr[3] = 32'h0000_0004; fr[10] = 32'h0003_0004;
    run_frame(lat, nd, be, f, np, pm, np2, fe);
    total++; if (f !== 4'd0) $display("FAIL strict_bin0_freq: got %0d expected 0", f); else passed++;
  endtask

  task automatic test_threshold();
    int lat, nd, be; logic [3:0] f, fe; logic np, np2; logic [31:0] pm;
    clear_frame(); fr[1] = 32'h0101_0000;
    run_frame(lat, nd, be, f, np, pm, np2, fe);
    total++; if (np2 !== 1'b0) $display("FAIL thr_above_nopeak: got %b expected 0", np2); else passed++;
    total++; if (freq2 !== 4'd1) $display("FAIL thr_above_freq: got %0d expected 1", freq2); else passed++;
  endtask

  task automatic test_back_to_back();
    int ovf_n = 0, ovf_k = -1, nd = 0, d1_k = -1, d2_k = -1;
    logic [3:0] d1_f = 4'hx, d2_f = 4'hx;
    logic b17 = 1'bx, b18 = 1'bx;
    clear_frame(); fr[4] = 32'h0010_0000;
    fft_valid = 1'b1;
    @(posedge clk); #1;
    fft_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin clear_frame(); fr[9] = 32'h0100_0000; fft_valid = 1'b1; end
      if (k == 17) begin clear_frame(); fr[12] = 32'h0020_0000; fft_valid = 1'b1; end
      @(posedge clk); #1;
      fft_valid = 1'b0;
      if (ovf === 1'b1) begin ovf_n++; ovf_k = k; end
      if (k == 17) b17 = busy;
      if (k == 18) b18 = busy;
      if (done === 1'b1) begin
        nd++;
        if (d1_k < 0) begin d1_k = k; d1_f = freq; end
        else if (d2_k < 0) begin d2_k = k; d2_f = freq; end
      end
    end
    total++; if (ovf_n !== 1 || ovf_k !== 5) $display("FAIL ovf_pulse: got %0d pulses last at %0d expected 1 at 5", ovf_n, ovf_k); else passed++;
    total++; if (d1_k !== 17) $display("FAIL b2b_first_done: got %0d expected 17", d1_k); else passed++;
    total++; if (d1_f !== 4'd4) $display("FAIL b2b_first_freq: got %0d expected 4", d1_f); else passed++;
    total++; if (d2_k !== 34) $display("FAIL b2b_second_done: got %0d expected 34", d2_k); else passed++;
    total++; if (d2_f !== 4'd12) $display("FAIL b2b_second_freq: got %0d expected 12", d2_f); else passed++;
    total++; if (nd !== 2) $display("FAIL b2b_done_count: got %0d expected 2", nd); else passed++;
    total++; if ({b17, b18} !== 2'b01) $display("FAIL b2b_busy_gap: got %b expected 01", {b17, b18}); else passed++;
  endtask

  task automatic test_reset_abort();
    int nd = 0;
    logic [4:0] outs = 5'bx;
    int lat, nd2, be; logic [3:0] f, fe; logic np, np2; logic [31:0] pm;
    clear_frame(); fr[6] = 32'h0040_0000;
    fft_valid = 1'b1;
    @(posedge clk); #1;
    fft_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      rst = (k == 8);
      @(posedge clk); #1;
      rst = 1'b0;
      if (k == 8) outs = {busy, done, ovf, nopeak, |freq};
      if (done === 1'b1) nd++;
    end
    total++; if (outs !== 5'b00000) $display("FAIL abort_outputs: got %b expected 00000", outs); else passed++;
    total++; if (nd !== 0) $display("FAIL abort_done_count: got %0d expected 0", nd); else passed++;
    clear_frame(); fr[2] = 32'h0000_0300;
    run_frame(lat, nd2, be, f, np, pm, np2, fe);
    total++; if (lat !== 17) $display("FAIL after_abort_latency: got %0d expected 17", lat); else passed++;
    total++; if (f !== 4'd2) $display("FAIL after_abort_freq: got %0d expected 2", f); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_bin();
    test_tie();
    test_max_neg();
    test_all_zero();
    test_strict_order();
    test_threshold();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
